// File: rtl/spw_rx_packet_collector.sv
// Collects SpaceWire receive-FIFO bytes into little-endian 32-bit stream beats,
// framing packets on EOP/EEP and keeping per-packet length and error statistics.
module spw_rx_packet_collector #(
    parameter int unsigned MAX_PKT_BYTES = 4096
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic        collect_en,
    input  logic        rx_f_empty,
    output logic        rx_rd_en,
    input  logic [8:0]  rx_data_flag,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        pkt_done,
    output logic [15:0] pkt_len,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    localparam logic [15:0] MaxBytes = 16'(MAX_PKT_BYTES);

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic        init_q;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] tdata_q, tdata_d;
    logic [3:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;
    logic        pkt_done_q, pkt_done_d;
    logic [15:0] pkt_len_q, pkt_len_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic is_term;
    assign is_term = rx_data_flag[8] && (rx_data_flag[7:1] == 7'd0);

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        byte_cnt_d  = byte_cnt_q;
        ovf_d       = ovf_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        pkt_done_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        rx_rd_en    = 1'b0;

        unique case (state_q)
            StFetch: begin
                // init_q holds off the first strobe until one edge after reset release
                if (init_q && collect_en && !rx_f_empty) begin
                    rx_rd_en = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                state_d = StFetch;
                if (!rx_data_flag[8]) begin
                    if (byte_cnt_q < MaxBytes) begin
                        tdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data_flag[7:0];
                        tkeep_d[byte_idx_q]                = 1'b1;
                        byte_cnt_d                         = byte_cnt_q + 16'd1;
                        if (byte_idx_q == 2'd3) begin
                            byte_idx_d = 2'd0;
                            tlast_d    = 1'b0;
                            tuser_d    = 1'b0;
                            tvalid_d   = 1'b1;
                            state_d    = StHold;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (is_term) begin
                    tlast_d    = 1'b1;
                    tuser_d    = ovf_q | rx_data_flag[0];
                    tvalid_d   = 1'b1;
                    byte_idx_d = 2'd0;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (m_tready) begin
                    tvalid_d = 1'b0;
                    tkeep_d  = 4'd0;
                    tdata_d  = 32'd0;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
                    state_d  = StFetch;
                    if (tlast_q) begin
                        pkt_done_d  = 1'b1;
                        pkt_len_d   = byte_cnt_q;
                        pkt_count_d = pkt_count_q + 16'd1;
                        if (tuser_q) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        byte_cnt_d = 16'd0;
                        ovf_d      = 1'b0;
                    end
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StFetch;
            init_q      <= 1'b0;
            byte_idx_q  <= 2'd0;
            byte_cnt_q  <= 16'd0;
            ovf_q       <= 1'b0;
            tdata_q     <= 32'd0;
            tkeep_q     <= 4'd0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_len_q   <= 16'd0;
            pkt_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            byte_idx_q  <= byte_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            ovf_q       <= ovf_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            pkt_done_q  <= pkt_done_d;
            pkt_len_q   <= pkt_len_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tkeep   = tkeep_q;
    assign m_tlast   = tlast_q;
    assign m_tuser   = tuser_q;
    assign m_tvalid  = tvalid_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/spw_rx_packet_collector.md
SPW_RX_PACKET_COLLECTOR -- requirements
Module: spw_rx_packet_collector

Interface
REQ-001 SHALL have parameter MAX_PKT_BYTES, default 4096, meaning maximum payload bytes accepted per packet (range 1..65535).
REQ-002 SHALL have port pclk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port collect_en  input  1  high permits new receive-FIFO reads.
REQ-005 SHALL have port rx_f_empty  input  1  receive FIFO empty.
REQ-006 SHALL have port rx_rd_en  output  1  receive FIFO read strobe, one-cycle pulse.
REQ-007 SHALL have port rx_data_flag  input  9  FIFO word: bit8=0 data byte [7:0]; bit8=1 control, 0x00=EOP, 0x01=EEP.
REQ-008 SHALL have ports m_tdata output 32, m_tkeep output 4, m_tlast output 1, m_tuser output 1 (packet error), m_tvalid output 1, m_tready input 1: output word stream.
REQ-009 SHALL have port pkt_done  output  1  one-cycle pulse when a tlast beat is accepted.
REQ-010 SHALL have port pkt_len  output  16  payload byte count of last completed packet.
REQ-011 SHALL have ports pkt_count output 16 and err_count output 16: completed packets and errored packets, wrapping mod 2^16.

Function
REQ-012 SHALL run a three-state FSM: FETCH, WAIT, HOLD.
REQ-013 In FETCH, SHALL assert rx_rd_en for one cycle and enter WAIT iff collect_en=1 and rx_f_empty=0; otherwise stay in FETCH with rx_rd_en=0.
REQ-014 SHALL sample rx_data_flag in WAIT (one-cycle FIFO read latency); at most one read outstanding, so rx_rd_en is never high on consecutive cycles.
REQ-015 Data byte in WAIT, byte count < MAX_PKT_BYTES: SHALL write it to lane byte_idx (lane 0 = m_tdata[7:0], little-endian), set that tkeep bit, increment byte_idx and byte count.
REQ-016 After lane 3 is filled: SHALL present the word with tkeep=1111, tlast=0, m_tvalid=1, byte_idx=0, enter HOLD; otherwise return to FETCH.
REQ-017 EOP in WAIT: SHALL present the partial word with tkeep for filled lanes, tlast=1, m_tuser=overflow flag; enter HOLD.
REQ-018 EOP with byte_idx=0 (empty packet or length multiple of 4): SHALL present a null beat, tkeep=0000, tdata=0, tlast=1.
REQ-019 EEP: SHALL behave as EOP with m_tuser=1.
REQ-020 Other control codes (bit8=1, data not 0x00/0x01): SHALL be discarded, no state change except return to FETCH.
REQ-021 Data byte when byte count = MAX_PKT_BYTES: SHALL drop it, set overflow flag, return to FETCH; the terminating beat carries m_tuser=1.
REQ-022 In HOLD, m_tdata/tkeep/tlast/tuser SHALL stay stable while m_tvalid=1 and m_tready=0; collect_en is ignored in HOLD.
REQ-023 On m_tvalid&m_tready: SHALL clear m_tvalid and tkeep, return to FETCH the next cycle; m_tready before m_tvalid has no effect.
REQ-024 On acceptance of a tlast beat SHALL, in the same edge: pulse pkt_done; load pkt_len with the accepted byte count (excluding dropped bytes); increment pkt_count; increment err_count if m_tuser=1; clear byte count and overflow flag.
REQ-025 collect_en deasserted mid-packet SHALL only pause reads; packet state is retained.
REQ-026 Counters SHALL wrap 0xFFFF->0x0000 without flag.

Reset
REQ-027 resetn=0 SHALL asynchronously force FETCH, rx_rd_en=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tuser=0, pkt_done=0, pkt_len=0, pkt_count=0, err_count=0, byte_idx=0, byte count=0, overflow flag=0.
REQ-028 Reset mid-packet SHALL abandon the partial packet; a FIFO word read in flight is lost; no beat emitted for it.
REQ-029 First rx_rd_en after resetn release SHALL be no earlier than the second rising edge.

Verification
REQ-030 Bytes 11,22,33,44,55 then EOP, m_tready=1 -> beats {44332211,1111,last0}, {00000055,0001,last1,user0}; pkt_len=5, pkt_count=1.
REQ-031 Bytes A1..A4 then EEP -> beats {A4A3A2A1,1111,last0}, {0,0000,last1,user1}; pkt_len=4, err_count=1.
REQ-032 EOP only -> one null beat tkeep=0000, tlast=1; pkt_len=0, pkt_count=1.
REQ-033 MAX_PKT_BYTES=4, bytes 1..6 then EOP -> beat {04030201,1111}, null tlast beat user=1; pkt_len=4, err_count=1.
REQ-034 m_tready=0 for 10 cycles on a full beat -> outputs stable, rx_rd_en=0 throughout; continuous FIFO -> rx_rd_en never two consecutive cycles.
REQ-035 resetn pulsed low after 2 bytes of a packet -> all outputs at reset values; next packet 7 bytes then EOP yields pkt_len=7.
